rgmii_rx_decode: RTL

Receive-side RGMII decoder directly downstream of the generic input DDR stage. Consumes the per-edge nibble and control samples for RXD[3:0]/RX_CTL from a 5-bit-wide `iddr` instance. Produces a byte-wide GMII receive stream with a per-byte valid strobe, covering both 1000 Mb/s DDR mode and 10/100 Mb/s nibble mode. Also decodes RGMII in-band link status and false-carrier/carrier-extend indications for the MAC and management logic.

---
 rtl/rgmii_rx_decode.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/rgmii_rx_decode.sv
// RGMII receive decoder: turns iddr per-edge samples into a GMII byte stream
// (gigabit DDR or 10/100 nibble mode) and decodes in-band link status.
`timescale 1ns / 1ps

module rgmii_rx_decode #(
   parameter int INBAND_FILTER = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] rxd_q1,
   input  logic [3:0] rxd_q2,
   input  logic       ctl_q1,
   input  logic       ctl_q2,
   input  logic       mii_select,
   output logic [7:0] gmii_rxd,
   output logic       gmii_rx_dv,
   output logic       gmii_rx_er,
   output logic       gmii_rx_valid,
   output logic       false_carrier,
   output logic       carrier_ext,
   output logic       link_up,
   output logic [1:0] link_speed,
   output logic       full_duplex
);

   typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

   localparam logic [3:0] FILTER = 4'(INBAND_FILTER);

   logic       dv;
   logic       er;
   logic       cand;
   logic [3:0] cnt;
   logic [3:0] cnt_next;
   logic [3:0] last_nib;
   logic [3:0] low_nib;
   logic       low_er;
   logic       mode;
   logic       toggle;
   state_t     state;

   assign dv   = ctl_q1;
   assign er   = ctl_q1 ^ ctl_q2;
   assign cand = !ctl_q1 && !ctl_q2 && (rxd_q1 == rxd_q2);

   // NOTE: cnt_next gets a default before any branch so no latch is inferred.
   always_comb begin
      cnt_next = 4'd0;
      if (cand) begin
         if (cnt != 4'd0 && rxd_q1 == last_nib)
            cnt_next = (cnt == 4'hF) ? cnt : cnt + 4'd1;
         else
            cnt_next = 4'd1;
      end
   end

   // NOTE: all state below uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         mode          <= 1'b0;
         toggle        <= 1'b0;
         low_nib       <= 4'h0;
         low_er        <= 1'b0;
         cnt           <= 4'd0;
         last_nib      <= 4'h0;
         gmii_rxd      <= 8'h00;
         gmii_rx_dv    <= 1'b0;
         gmii_rx_er    <= 1'b0;
         gmii_rx_valid <= 1'b0;
         false_carrier <= 1'b0;
         carrier_ext   <= 1'b0;
         link_up       <= 1'b0;
         link_speed    <= 2'b00;
         full_duplex   <= 1'b0;
      end else begin
         toggle        <= ~toggle;
         false_carrier <= !dv && er && (rxd_q1 == 4'hE);
         carrier_ext   <= !dv && er && (rxd_q1 == 4'hF);

         // Mode only changes between frames, never under a partial byte.
         if (!dv && state == IDLE)
            mode <= mii_select;

         if (!mode) begin
            gmii_rxd      <= {rxd_q2, rxd_q1};
            gmii_rx_dv    <= dv;
            gmii_rx_er    <= er;
            gmii_rx_valid <= 1'b1;
         end else begin
            gmii_rx_valid <= 1'b0;
            case (state)
               IDLE: begin
                  if (dv) begin
                     low_nib <= rxd_q1;
                     low_er  <= er;
                     state   <= LOW;
                  end else begin
                     gmii_rx_valid <= toggle;
                     if (toggle) begin
                        gmii_rxd   <= {rxd_q1, rxd_q1};
                        gmii_rx_dv <= 1'b0;
                        gmii_rx_er <= er;
                     end
                  end
               end
               LOW: begin
                  gmii_rx_valid <= 1'b1;
                  gmii_rx_dv    <= 1'b1;
                  if (dv) begin
                     gmii_rxd   <= {rxd_q1, low_nib};
                     gmii_rx_er <= low_er | er;
                     state      <= HIGH;
                  end else begin
                     // Frame ended on an odd nibble: flush it as an error byte.
                     gmii_rxd   <= {4'h0, low_nib};
                     gmii_rx_er <= 1'b1;
                     state      <= IDLE;
                  end
               end
               HIGH: begin
                  if (dv) begin
                     low_nib <= rxd_q1;
                     low_er  <= er;
                     state   <= LOW;
                  end else begin
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end

         cnt <= cnt_next;
         if (cand)
            last_nib <= rxd_q1;
         if (cand && cnt_next == FILTER && rxd_q1[2:1] != 2'b11) begin
            link_up     <= rxd_q1[0];
            link_speed  <= rxd_q1[2:1];
            full_duplex <= rxd_q1[3];
         end
      end
   end

endmodule
